// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for the byte-wide data memory: each 16-bit load or store
// is split into two little-endian byte accesses, and the pipeline is stalled meanwhile.
module mem_access_ctrl #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 16,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [ADDR_W-1:0] req_adr,
    input  logic [WORD_W-1:0] store_data,
    output logic [WORD_W-1:0] load_data,
    output logic              done,
    output logic              stall,
    output logic              req_err,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] adr,
    output logic [BYTE_W-1:0] writeData,
    input  logic [BYTE_W-1:0] data
);

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t              state;
    state_t              next_state;
    logic                op_store;
    logic [ADDR_W-1:0]   adr_q;
    logic [WORD_W-1:0]   store_q;
    logic [BYTE_W-1:0]   lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req_load || req_store) next_state = LO;
            LO:   next_state = HI;
            HI:   next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // When both request lines are high the store wins and the conflict is flagged one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_store  <= 1'b0;
            adr_q     <= '0;
            store_q   <= '0;
            lo_q      <= '0;
            load_data <= '0;
            req_err   <= 1'b0;
        end else begin
            req_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_load || req_store) begin
                        op_store <= req_store;
                        adr_q    <= req_adr;
                        store_q  <= store_data;
                        req_err  <= req_load & req_store;
                    end
                end
                LO: begin
                    if (!op_store) lo_q <= data;
                end
                HI: begin
                    if (!op_store) load_data <= {data, lo_q};
                end
                default: ;
            endcase
        end
    end

    // The write enable is gated by rst so that no byte commits on an edge that resets the controller.
    always_comb begin
        memRead   = 1'b0;
        memWrite  = 1'b0;
        adr       = '0;
        writeData = '0;
        done      = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = req_load | req_store;
            end
            LO: begin
                stall     = 1'b1;
                adr       = adr_q;
                memRead   = ~op_store;
                memWrite  = op_store & ~rst;
                writeData = op_store ? store_q[BYTE_W-1:0] : '0;
            end
            HI: begin
                stall     = 1'b1;
                adr       = adr_q + 1'b1;
                memRead   = ~op_store;
                memWrite  = op_store & ~rst;
                writeData = op_store ? store_q[WORD_W-1:BYTE_W] : '0;
            end
            RESP: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory interface, located in the pipeline MEM stage.
- Accepts 16-bit load/store requests from the pipeline and drives the byte-wide data memory (1024 x 8, asynchronous read, write on posedge clk) over memRead/memWrite/adr/writeData/data.
- Splits each word access into two byte accesses, little-endian, and assembles read data.
- Asserts stall toward the pipeline until the access completes.

Parameters:
- ADDR_W, 10, byte address width; the address space wraps modulo 2^ADDR_W.
- WORD_W, 16, pipeline word width; fixed at 2 x BYTE_W.
- BYTE_W, 8, memory data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_load  in  1  load request; sampled only in IDLE.
- req_store  in  1  store request; sampled only in IDLE.
- req_adr  in  ADDR_W  byte address of the word's low byte; unaligned addresses allowed.
- store_data  in  WORD_W  store word.
- load_data  out  WORD_W  assembled load word.
- done  out  1  one-cycle completion pulse.
- stall  out  1  pipeline hold.
- req_err  out  1  one-cycle pulse on a conflicting request.
- memRead  out  1  memory read enable.
- memWrite  out  1  memory write enable.
- adr  out  ADDR_W  memory byte address.
- writeData  out  BYTE_W  memory write byte.
- data  in  BYTE_W  memory read byte, combinational from adr.

Behaviour:
- Reset (sync, rst high at posedge):
  - state=IDLE.
  - load_data=0, done=0, req_err=0, internal latches=0.
- memRead/memWrite/adr/writeData are decoded from state. memWrite is additionally gated by ~rst combinationally, so no write commits at an edge where rst=1.
- FSM states: IDLE, LO, HI, RESP.
- IDLE:
  - memRead=0, memWrite=0, adr=0, writeData=0.
  - On req_load|req_store: latch op, req_adr and store_data; go to LO.
  - Both asserted: store wins and req_err pulses in the following cycle (registered).
- LO:
  - adr=adr_q.
  - Load: memRead=1; data is captured into the low byte at the posedge.
  - Store: memWrite=1, writeData=store_q[7:0].
  - Go to HI.
- HI:
  - adr=(adr_q+1) mod 2^ADDR_W, so 1023 wraps to 0.
  - Load: memRead=1; data is captured into the high byte.
  - Store: memWrite=1, writeData=store_q[15:8].
  - Go to RESP.
- RESP:
  - done=1 for exactly this cycle; memRead=memWrite=0.
  - For a load, load_data={hi,lo} is valid from this cycle and held until the next load's RESP.
  - A store leaves load_data unchanged.
  - Go to IDLE. Requests are not sampled in RESP.
- stall = (state==IDLE & (req_load|req_store)) | state==LO | state==HI. It is combinational and deasserted in RESP.
- Latency: request seen in IDLE at cycle 0 -> LO at cycle 1 -> HI at cycle 2 -> done at cycle 3. Throughput is one access per 4 cycles; a held request is re-accepted at cycle 4.
- The pipeline holds req_* and operands stable while stall=1; changes are ignored after the latch.
- Reset mid-operation (LO/HI/RESP):
  - Abort and return to IDLE; no done pulse.
  - A store interrupted after LO leaves the low byte written and the high byte unwritten. This is accepted behaviour.
  - A store with rst high in LO writes nothing.

Test Plan:
1. Reset, then store 0x0C12 at req_adr=0 -> memWrite high in cycles 1-2 (adr 0 then 1, bytes 0x12 then 0x0C); done at cycle 3; mem[0]=0x12, mem[1]=0x0C; stall high in cycles 0-2.
2. Following scenario 1, load from 0 -> memRead cycles 1-2; load_data=0x0C12 with done at cycle 3; memWrite stays 0.
3. Store 0xBEEF at req_adr=1023 -> mem[1023]=0xEF, mem[0]=0xBE (wrap); a subsequent load from 1023 returns 0xBEEF.
4. req_load=req_store=1, adr=5, data 0x1234 -> a store is performed (mem[5]=0x34, mem[6]=0x12); req_err pulses at cycle 1; load_data is unchanged.
5. Start store 0xAAAA at adr 8, with rst=1 during LO -> mem[8] and mem[9] unchanged; state returns to IDLE; no done; all outputs are at reset values next cycle.
6. req_load held high continuously from adr 0 -> done at cycles 3, 7, 11; stall low only in RESP cycles; load_data stable between done pulses.
